// File: rtl/mctrl_pkg.sv
// mctrl_pkg: shared encodings for the multicycle control FSM.
//   Opcode constants, FSM state enum, and the alu_op / pc_sel / wb_sel
//   encodings driven onto the datapath.
package mctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_ANDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_BNE  = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;
  localparam logic [3:0] OP_CALL = 4'd10;
  localparam logic [3:0] OP_RET  = 4'd11;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_AND  = 2'd2;
  localparam logic [1:0] ALU_PASS = 2'd3;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

endpackage

// File: rtl/mctrl_decode.sv
// mctrl_decode: combinational opcode classifier.
//   opcode     in  4  latched IR[15:12]
//   is_rtype   out 1  ADD / SUB / AND
//   is_itype   out 1  ADDI / ANDI
//   is_load    out 1  LW
//   is_store   out 1  SW
//   is_branch  out 1  BEQ / BNE
//   is_jump    out 1  JMP / CALL / RET
//   is_illegal out 1  opcodes 12..15
module mctrl_decode
  import mctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_rtype,
  output logic       is_itype,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jump,
  output logic       is_illegal
);

  always_comb begin
    is_rtype   = 1'b0;
    is_itype   = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND:  is_rtype  = 1'b1;
      OP_ADDI, OP_ANDI:        is_itype  = 1'b1;
      OP_LW:                   is_load   = 1'b1;
      OP_SW:                   is_store  = 1'b1;
      OP_BEQ, OP_BNE:          is_branch = 1'b1;
      OP_JMP, OP_CALL, OP_RET: is_jump   = 1'b1;
      default:                 is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for the multicycle 16-bit datapath.
//   Sequences FETCH/DECODE/EXEC/MEM/WB and drives all datapath enables,
//   mux selects and the shared memory port handshake.
//   Optional feature macro: MCTRL_ILLEGAL_TRAP_EN (illegal opcode traps and
//   raises sticky 'illegal'; otherwise illegal opcodes retire as NOPs).
//
//   clk            in  1      rising-edge clock
//   rst_n          in  1      asynchronous active-low reset
//   opcode         in  4      IR[15:12]
//   alu_zero       in  1      ALU result == 0
//   mem_ack        in  1      memory completes current request
//   ir_we/pc_we/reg_we out 1  register write enables
//   pc_sel         out 2      0 PC+1, 1 branch, 2 jump, 3 rs1 (RET)
//   wb_sel         out 2      0 ALU, 1 memory, 2 PC (link)
//   wb_link        out 1      destination forced to r7
//   alu_op         out 2      0 ADD, 1 SUB, 2 AND, 3 PASS
//   alu_src_imm    out 1      ALU B = immediate
//   sel_s_fmt      out 1      S-format operand field select (SW)
//   mem_req/mem_we out 1      memory request / write
//   mem_addr_sel   out 1      0 PC, 1 ALU result
//   instr_retired  out CNT_W  completed-instruction count
//   illegal        out 1      sticky illegal flag (macro only)
//
//   state  | meaning
//   START  | one idle cycle after reset
//   FETCH  | instruction read, waits for mem_ack
//   DECODE | register read; jumps complete here
//   EXEC   | ALU operation; branches complete here
//   MEM    | data access, waits for mem_ack
//   WB     | register write-back
//   TRAP   | halted on illegal opcode (macro only)
module multicycle_control
  import mctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic [1:0]       pc_sel,
  output logic [1:0]       wb_sel,
  output logic             wb_link,
  output logic [1:0]       alu_op,
  output logic             alu_src_imm,
  output logic             sel_s_fmt,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic [CNT_W-1:0] instr_retired
`ifdef MCTRL_ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  state_t state;
  logic   retire;
  logic   is_rtype, is_itype, is_load, is_store, is_branch, is_jump, is_illegal;
  logic   br_taken;

  mctrl_decode u_decode (
    .opcode     (opcode),
    .is_rtype   (is_rtype),
    .is_itype   (is_itype),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .is_jump    (is_jump),
    .is_illegal (is_illegal)
  );

  assign br_taken = ((opcode == OP_BEQ) &&  alu_zero) ||
                    ((opcode == OP_BNE) && !alu_zero);

`ifdef MCTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`endif

  // Completing transitions: one pulse per instruction in its last cycle.
  always_comb begin
    retire = 1'b0;
    case (state)
      ST_DECODE: begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
        retire = is_jump;
`else
        retire = is_jump | is_illegal;
`endif
      end
      ST_EXEC: retire = is_branch;
      ST_MEM:  retire = mem_ack & is_store;
      ST_WB:   retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_START;
      instr_retired <= '0;
`ifdef MCTRL_ILLEGAL_TRAP_EN
      illegal_q     <= 1'b0;
`endif
    end else begin
      if (retire) instr_retired <= instr_retired + CNT_W'(1);
      case (state)
        ST_START: state <= ST_FETCH;
        ST_FETCH: if (mem_ack) state <= ST_DECODE;
        ST_DECODE: begin
          if (is_jump) begin
            state <= ST_FETCH;
          end else if (is_illegal) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
            state     <= ST_TRAP;
            illegal_q <= 1'b1;
`else
            state <= ST_FETCH;
`endif
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_load | is_store)      state <= ST_MEM;
          else if (is_rtype | is_itype) state <= ST_WB;
          else                          state <= ST_FETCH;
        end
        ST_MEM: if (mem_ack) state <= is_store ? ST_FETCH : ST_WB;
        ST_WB:  state <= ST_FETCH;
`ifdef MCTRL_ILLEGAL_TRAP_EN
        ST_TRAP: state <= ST_TRAP;
`endif
        default: state <= ST_START;
      endcase
    end
  end

  always_comb begin
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    reg_we       = 1'b0;
    pc_sel       = PC_INC;
    wb_sel       = WB_ALU;
    wb_link      = 1'b0;
    alu_op       = ALU_ADD;
    alu_src_imm  = 1'b0;
    sel_s_fmt    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          pc_sel = PC_INC;
        end
      end
      ST_DECODE: begin
        sel_s_fmt = is_store;
        case (opcode)
          OP_JMP: begin
            pc_we  = 1'b1;
            pc_sel = PC_JUMP;
          end
          OP_CALL: begin
            pc_we   = 1'b1;
            pc_sel  = PC_JUMP;
            reg_we  = 1'b1;
            wb_sel  = WB_PC;
            wb_link = 1'b1;
          end
          OP_RET: begin
            pc_we  = 1'b1;
            pc_sel = PC_REG;
          end
          default: ;
        endcase
      end
      ST_EXEC: begin
        sel_s_fmt   = is_store;
        alu_src_imm = is_itype | is_load | is_store;
        case (opcode)
          OP_SUB, OP_BEQ, OP_BNE: alu_op = ALU_SUB;
          OP_AND, OP_ANDI:        alu_op = ALU_AND;
          default:                alu_op = ALU_ADD;
        endcase
        if (is_branch && br_taken) begin
          pc_we  = 1'b1;
          pc_sel = PC_BRANCH;
        end
      end
      ST_MEM: begin
        // Address stays on the ALU (rs1 + imm) for the whole access.
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        alu_src_imm  = 1'b1;
        sel_s_fmt    = is_store;
      end
      ST_WB: begin
        reg_we = 1'b1;
        wb_sel = is_load ? WB_MEM : WB_ALU;
      end
      default: ;
    endcase
  end

endmodule
